// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse per 0->1 transition of each bit.
// Pulse is combinational from the current input and the last-cycle register; no backpressure.
module edge_detector #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] signal_in,
  output logic [WIDTH-1:0] edge_detect_pulse
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= signal_in;
    end
  end

  assign edge_detect_pulse = signal_in & ~prev;

endmodule

// File: rtl/button_conditioner.sv
// Per-bit debouncer (shared sample tick, saturating per-bit counters) plus rising-edge pulse.
// Level asserts on the posedge of the PULSE_CNT_MAX-th high tick, drops 1 cycle after a low; no backpressure.
module button_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW = (PULSE_CNT_MAX > 0) ? $clog2(PULSE_CNT_MAX + 1) : 1;
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PULSE_SAT   = CW'(PULSE_CNT_MAX);

  logic [SW-1:0] sample_cnt;
  logic          sample_tick;
  logic [CW-1:0] sat_cnt [WIDTH];

  assign sample_tick = (sample_cnt == SAMPLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (sample_tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + SW'(1);
    end
  end

  // A low input on any cycle restarts qualification; only ticks advance the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        sat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!glitchy_signal[i]) begin
          sat_cnt[i] <= '0;
        end else if (sample_tick && (sat_cnt[i] < PULSE_SAT)) begin
          sat_cnt[i] <= sat_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    debounced_signal = '0;
    for (int i = 0; i < WIDTH; i++) begin
      debounced_signal[i] = (sat_cnt[i] == PULSE_SAT);
    end
  end

  edge_detector #(
    .WIDTH(WIDTH)
  ) u_edge_detector (
    .clk              (clk),
    .rst_n            (rst_n),
    .signal_in        (debounced_signal),
    .edge_detect_pulse(edge_pulse)
  );

endmodule
